// File: rtl/frog_game_pkg.sv
// Shared types, constants and helpers for the frog game supervisor.
package frog_game_pkg;

  localparam int COORD_W_DEF = 12;
  localparam int MAX_COORD_W = 32;
  localparam int MAX_VEC_W   = 512;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_HIT  = 2'd1,
    ST_WIN  = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  // Extract channel k (w bits wide) from a packed coordinate vector; caller narrows the result.
  function automatic logic [MAX_COORD_W-1:0] unpack_coord(input logic [MAX_VEC_W-1:0] vec,
                                                          input int k, input int w);
    logic [MAX_COORD_W-1:0] mask;
    mask = {MAX_COORD_W{1'b1}} >> (MAX_COORD_W - w);
    return MAX_COORD_W'(vec >> (k * w)) & mask;
  endfunction

endpackage

// File: rtl/frog_game_ctrl_if.sv
// Frame, frog/obstacle geometry and status bundle of the frog game supervisor.
// The o_invuln status bit exists only when FROG_INVULN_EN is defined.
interface frog_game_ctrl_if
  import frog_game_pkg::*;
#(
  parameter int N_OBJ   = 3,
  parameter int COORD_W = COORD_W_DEF,
  parameter int SCORE_W = 8
);
  logic                       i_animate;
  logic                       i_start;
  logic [COORD_W-1:0]         i_frog_x1;
  logic [COORD_W-1:0]         i_frog_x2;
  logic [COORD_W-1:0]         i_frog_y1;
  logic [COORD_W-1:0]         i_frog_y2;
  logic [N_OBJ*COORD_W-1:0]   i_obj_x1;
  logic [N_OBJ*COORD_W-1:0]   i_obj_x2;
  logic [N_OBJ*COORD_W-1:0]   i_obj_y1;
  logic [N_OBJ*COORD_W-1:0]   i_obj_y2;
  logic [N_OBJ-1:0]           i_obj_en;
  logic [1:0]                 o_state;
  logic [3:0]                 o_lives;
  logic [SCORE_W-1:0]         o_score;
  logic [N_OBJ-1:0]           o_hit_mask;
  logic                       o_respawn;
`ifdef FROG_INVULN_EN
  logic                       o_invuln;

  modport master (
    output i_animate, i_start, i_frog_x1, i_frog_x2, i_frog_y1, i_frog_y2,
    output i_obj_x1, i_obj_x2, i_obj_y1, i_obj_y2, i_obj_en,
    input  o_state, o_lives, o_score, o_hit_mask, o_respawn, o_invuln
  );
  modport slave (
    input  i_animate, i_start, i_frog_x1, i_frog_x2, i_frog_y1, i_frog_y2,
    input  i_obj_x1, i_obj_x2, i_obj_y1, i_obj_y2, i_obj_en,
    output o_state, o_lives, o_score, o_hit_mask, o_respawn, o_invuln
  );
`else
  modport master (
    output i_animate, i_start, i_frog_x1, i_frog_x2, i_frog_y1, i_frog_y2,
    output i_obj_x1, i_obj_x2, i_obj_y1, i_obj_y2, i_obj_en,
    input  o_state, o_lives, o_score, o_hit_mask, o_respawn
  );
  modport slave (
    input  i_animate, i_start, i_frog_x1, i_frog_x2, i_frog_y1, i_frog_y2,
    input  i_obj_x1, i_obj_x2, i_obj_y1, i_obj_y2, i_obj_en,
    output o_state, o_lives, o_score, o_hit_mask, o_respawn
  );
`endif
endinterface

// File: rtl/frog_game_ctrl_box_overlap.sv
// Strict axis-aligned box overlap test; boxes that only share an edge do not overlap.
module box_overlap
  import frog_game_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic               en_i,
  input  logic [COORD_W-1:0] a_x1_i,
  input  logic [COORD_W-1:0] a_x2_i,
  input  logic [COORD_W-1:0] a_y1_i,
  input  logic [COORD_W-1:0] a_y2_i,
  input  logic [COORD_W-1:0] b_x1_i,
  input  logic [COORD_W-1:0] b_x2_i,
  input  logic [COORD_W-1:0] b_y1_i,
  input  logic [COORD_W-1:0] b_y2_i,
  output logic               hit_o
);
  assign hit_o = en_i && (a_x1_i < b_x2_i) && (a_x2_i > b_x1_i)
                      && (a_y1_i < b_y2_i) && (a_y2_i > b_y1_i);
endmodule

// File: rtl/frog_game_ctrl.sv
// Per-frame frog game supervisor: collision/goal detection, lives, score and respawn FSM.
// Optional FROG_INVULN_EN adds post-respawn invulnerability and the o_invuln output.
module frog_game_ctrl
  import frog_game_pkg::*;
#(
  parameter int N_OBJ       = 3,
  parameter int COORD_W     = COORD_W_DEF,
  parameter int LIVES       = 3,
  parameter int SCORE_W     = 8,
  parameter int GOAL_Y      = 40,
  parameter int HOLD_FRAMES = 60
) (
  input logic             i_clk,
  input logic             i_rst,
  frog_game_ctrl_if.slave bus
);
  localparam int                 TMR_W      = $clog2(HOLD_FRAMES + 1);
  localparam logic [TMR_W-1:0]   TMR_LAST   = TMR_W'(HOLD_FRAMES - 1);
  localparam logic [TMR_W-1:0]   TMR_ZERO   = {TMR_W{1'b0}};
  localparam logic [3:0]         LIVES_INIT = 4'(LIVES);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
  localparam logic [COORD_W-1:0] GOAL_LIM   = COORD_W'(GOAL_Y);

  state_e             state_q, state_d;
  logic [3:0]         lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [N_OBJ-1:0]   mask_q, mask_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               respawn_q, respawn_d;

  logic [N_OBJ-1:0]   ovl_s;
  logic               hit_s;
  logic               goal_s;
  logic               strobe_s;

  assign strobe_s = bus.i_animate;
  assign goal_s   = bus.i_frog_y1 < GOAL_LIM;

  for (genvar k = 0; k < N_OBJ; k++) begin : g_obj
    logic [COORD_W-1:0] x1_s, x2_s, y1_s, y2_s;
    assign x1_s = COORD_W'(unpack_coord(MAX_VEC_W'(bus.i_obj_x1), k, COORD_W));
    assign x2_s = COORD_W'(unpack_coord(MAX_VEC_W'(bus.i_obj_x2), k, COORD_W));
    assign y1_s = COORD_W'(unpack_coord(MAX_VEC_W'(bus.i_obj_y1), k, COORD_W));
    assign y2_s = COORD_W'(unpack_coord(MAX_VEC_W'(bus.i_obj_y2), k, COORD_W));

    box_overlap #(.COORD_W(COORD_W)) u_box (
      .en_i   (bus.i_obj_en[k]),
      .a_x1_i (bus.i_frog_x1),
      .a_x2_i (bus.i_frog_x2),
      .a_y1_i (bus.i_frog_y1),
      .a_y2_i (bus.i_frog_y2),
      .b_x1_i (x1_s),
      .b_x2_i (x2_s),
      .b_y1_i (y1_s),
      .b_y2_i (y2_s),
      .hit_o  (ovl_s[k])
    );
  end

`ifdef FROG_INVULN_EN
  logic [TMR_W-1:0] invuln_q, invuln_d;

  assign hit_s        = (|ovl_s) && (invuln_q == TMR_ZERO);
  assign bus.o_invuln = (invuln_q != TMR_ZERO);

  // Invulnerability window: reload on every respawn, count down per frame.
  always_comb begin
    invuln_d = invuln_q;
    if (respawn_d) begin
      invuln_d = TMR_W'(HOLD_FRAMES);
    end else if (strobe_s && (invuln_q != TMR_ZERO)) begin
      invuln_d = invuln_q - TMR_W'(1);
    end else begin
      invuln_d = invuln_q;
    end
  end

  // Invulnerability counter register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) invuln_q <= TMR_ZERO;
    else       invuln_q <= invuln_d;
  end
`else
  assign hit_s = |ovl_s;
`endif

  // State and datapath registers; async reset also drops a pending respawn.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_PLAY;
      lives_q   <= LIVES_INIT;
      score_q   <= {SCORE_W{1'b0}};
      mask_q    <= {N_OBJ{1'b0}};
      timer_q   <= TMR_ZERO;
      respawn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      score_q   <= score_d;
      mask_q    <= mask_d;
      timer_q   <= timer_d;
      respawn_q <= respawn_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PLAY: begin
        if (strobe_s && hit_s) begin
          state_d = (lives_q > 4'd1) ? ST_HIT : ST_OVER;
        end else if (strobe_s && goal_s) begin
          state_d = ST_WIN;
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_HIT, ST_WIN: begin
        if (strobe_s && (timer_q == TMR_LAST)) state_d = ST_PLAY;
        else                                   state_d = state_q;
      end
      ST_OVER: begin
        if (bus.i_start) state_d = ST_PLAY;
        else             state_d = ST_OVER;
      end
      default: state_d = ST_PLAY;
    endcase
  end

  // Lives, score, hit mask, hold timer and respawn pulse.
  always_comb begin
    lives_d   = lives_q;
    score_d   = score_q;
    mask_d    = mask_q;
    timer_d   = timer_q;
    respawn_d = 1'b0;
    case (state_q)
      ST_PLAY: begin
        if (strobe_s && hit_s) begin
          // Hit wins over a same-frame goal, so the score is left alone here.
          mask_d  = ovl_s;
          timer_d = TMR_ZERO;
          lives_d = lives_q - 4'd1;
        end else if (strobe_s && goal_s) begin
          timer_d = TMR_ZERO;
          if (score_q != SCORE_MAX) score_d = score_q + SCORE_ONE;
          else                      score_d = score_q;
        end else begin
          timer_d = timer_q;
        end
      end
      ST_HIT, ST_WIN: begin
        if (strobe_s && (timer_q == TMR_LAST)) begin
          timer_d   = TMR_ZERO;
          mask_d    = {N_OBJ{1'b0}};
          respawn_d = 1'b1;
        end else if (strobe_s) begin
          timer_d = timer_q + TMR_W'(1);
        end else begin
          timer_d = timer_q;
        end
      end
      ST_OVER: begin
        if (bus.i_start) begin
          lives_d   = LIVES_INIT;
          score_d   = {SCORE_W{1'b0}};
          mask_d    = {N_OBJ{1'b0}};
          timer_d   = TMR_ZERO;
          respawn_d = 1'b1;
        end else begin
          timer_d = timer_q;
        end
      end
      default: begin
        timer_d = TMR_ZERO;
      end
    endcase
  end

  assign bus.o_state    = state_q;
  assign bus.o_lives    = lives_q;
  assign bus.o_score    = score_q;
  assign bus.o_hit_mask = mask_q;
  assign bus.o_respawn  = respawn_q;

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Directed scoreboard bench for frog_game_ctrl; an extra instance with SCORE_W=2 checks saturation.
module tb_frog_game_ctrl;
  localparam logic [1:0] S_PLAY = 2'd0;
  localparam logic [1:0] S_HIT  = 2'd1;
  localparam logic [1:0] S_WIN  = 2'd2;
  localparam logic [1:0] S_OVER = 2'd3;
  localparam int HOLD = 60;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  frog_game_ctrl_if #(.N_OBJ(3), .COORD_W(12), .SCORE_W(8)) bus ();
  frog_game_ctrl_if #(.N_OBJ(3), .COORD_W(12), .SCORE_W(2)) bus2 ();

  frog_game_ctrl #(.N_OBJ(3), .COORD_W(12), .LIVES(3), .SCORE_W(8), .GOAL_Y(40),
                   .HOLD_FRAMES(HOLD)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  frog_game_ctrl #(.N_OBJ(3), .COORD_W(12), .LIVES(3), .SCORE_W(2), .GOAL_Y(40),
                   .HOLD_FRAMES(2)) dut2 (.i_clk(clk), .i_rst(rst), .bus(bus2));

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic [3:0] lives;
    logic [7:0] score;
    logic [2:0] mask;
    logic       resp;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [1:0] st, input logic [3:0] lv,
                          input logic [7:0] sc, input logic [2:0] mk, input logic rs);
    exp_t e;
    e.tag = tag; e.st = st; e.lives = lv; e.score = sc; e.mask = mk; e.resp = rs;
    exp_q.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard_underflow observed=empty expected=entry");
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, ".state"}, 32'(bus.o_state),    32'(e.st));
      chk({e.tag, ".lives"}, 32'(bus.o_lives),    32'(e.lives));
      chk({e.tag, ".score"}, 32'(bus.o_score),    32'(e.score));
      chk({e.tag, ".mask"},  32'(bus.o_hit_mask), 32'(e.mask));
      chk({e.tag, ".resp"},  32'(bus.o_respawn),  32'(e.resp));
    end
  endtask

  // One clock cycle with the given strobe/start, then compare against the queued expectation.
  task automatic step(input string tag, input logic a, input logic s, input logic [1:0] st,
                      input logic [3:0] lv, input logic [7:0] sc, input logic [2:0] mk,
                      input logic rs);
    push_exp(tag, st, lv, sc, mk, rs);
    @(negedge clk);
    bus.i_animate = a;
    bus.i_start   = s;
    @(negedge clk);
    bus.i_animate = 1'b0;
    bus.i_start   = 1'b0;
    check_pop();
  endtask

  task automatic set_frog(input logic [11:0] x1, input logic [11:0] y1,
                          input logic [11:0] x2, input logic [11:0] y2);
    bus.i_frog_x1 = x1; bus.i_frog_y1 = y1; bus.i_frog_x2 = x2; bus.i_frog_y2 = y2;
  endtask

  task automatic set_obj(input int k, input logic [11:0] x1, input logic [11:0] y1,
                         input logic [11:0] x2, input logic [11:0] y2);
    bus.i_obj_x1[k*12 +: 12] = x1;
    bus.i_obj_y1[k*12 +: 12] = y1;
    bus.i_obj_x2[k*12 +: 12] = x2;
    bus.i_obj_y2[k*12 +: 12] = y2;
  endtask

  // Quiet frames in PLAY after a respawn (long enough to outlast any invulnerability window).
  task automatic settle(input string tag, input logic [3:0] lv, input logic [7:0] sc);
    bus.i_obj_en = 3'b000;
    set_frog(12'd300, 12'd400, 12'd340, 12'd440);
`ifdef FROG_INVULN_EN
    for (int i = 0; i <= HOLD; i++) step(tag, 1'b1, 1'b0, S_PLAY, lv, sc, 3'b000, 1'b0);
`else
    step(tag, 1'b1, 1'b0, S_PLAY, lv, sc, 3'b000, 1'b0);
`endif
  endtask

  // Remaining HOLD-1 frames in HIT/WIN, the release frame, then the one-cycle respawn check.
  task automatic hold_release(input string tag, input logic [1:0] st, input logic [3:0] lv,
                              input logic [7:0] sc, input logic [2:0] mk);
    for (int i = 1; i < HOLD; i++) step({tag, ".hold"}, 1'b1, 1'b0, st, lv, sc, mk, 1'b0);
    step({tag, ".release"}, 1'b1, 1'b0, S_PLAY, lv, sc, 3'b000, 1'b1);
    step({tag, ".pulse_end"}, 1'b0, 1'b0, S_PLAY, lv, sc, 3'b000, 1'b0);
    settle({tag, ".settle"}, lv, sc);
  endtask

  initial begin
    bus.i_animate = 1'b0; bus.i_start = 1'b0; bus.i_obj_en = 3'b000;
    bus.i_obj_x1 = '0; bus.i_obj_x2 = '0; bus.i_obj_y1 = '0; bus.i_obj_y2 = '0;
    set_frog(12'd300, 12'd400, 12'd340, 12'd440);
    bus2.i_animate = 1'b0; bus2.i_start = 1'b0; bus2.i_obj_en = 3'b000;
    bus2.i_obj_x1 = '0; bus2.i_obj_x2 = '0; bus2.i_obj_y1 = '0; bus2.i_obj_y2 = '0;
    bus2.i_frog_x1 = 12'd300; bus2.i_frog_x2 = 12'd340;
    bus2.i_frog_y1 = 12'd30;  bus2.i_frog_y2 = 12'd70;

    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    step("reset", 1'b0, 1'b0, S_PLAY, 4'd3, 8'd0, 3'b000, 1'b0);

    // Edge touch and disabled channel
    set_frog(12'd300, 12'd400, 12'd320, 12'd440);
    set_obj(0, 12'd320, 12'd410, 12'd400, 12'd430);
    set_obj(1, 12'd300, 12'd400, 12'd320, 12'd440);
    bus.i_obj_en = 3'b001;
    step("edge_touch", 1'b1, 1'b0, S_PLAY, 4'd3, 8'd0, 3'b000, 1'b0);
    step("obj1_disabled", 1'b1, 1'b0, S_PLAY, 4'd3, 8'd0, 3'b000, 1'b0);
    step("start_in_play", 1'b0, 1'b1, S_PLAY, 4'd3, 8'd0, 3'b000, 1'b0);

    // Overlap with obj0
    set_frog(12'd300, 12'd400, 12'd340, 12'd440);
    step("hit1", 1'b1, 1'b0, S_HIT, 4'd2, 8'd0, 3'b001, 1'b0);
    step("hit1.no_strobe", 1'b0, 1'b0, S_HIT, 4'd2, 8'd0, 3'b001, 1'b0);
    hold_release("hit1", S_HIT, 4'd2, 8'd0, 3'b001);

    // Goal
    set_frog(12'd300, 12'd30, 12'd340, 12'd70);
    step("goal", 1'b1, 1'b0, S_WIN, 4'd2, 8'd1, 3'b000, 1'b0);
    hold_release("goal", S_WIN, 4'd2, 8'd1, 3'b000);

    // Hit and goal in the same frame
    set_frog(12'd300, 12'd30, 12'd340, 12'd70);
    set_obj(2, 12'd290, 12'd20, 12'd350, 12'd80);
    bus.i_obj_en = 3'b100;
    step("priority", 1'b1, 1'b0, S_HIT, 4'd1, 8'd1, 3'b100, 1'b0);
    hold_release("priority", S_HIT, 4'd1, 8'd1, 3'b100);

    // Last life lost, frozen, restart
    set_frog(12'd300, 12'd400, 12'd340, 12'd440);
    bus.i_obj_en = 3'b001;
    step("over", 1'b1, 1'b0, S_OVER, 4'd0, 8'd1, 3'b001, 1'b0);
    step("over.frozen1", 1'b1, 1'b0, S_OVER, 4'd0, 8'd1, 3'b001, 1'b0);
    set_frog(12'd300, 12'd30, 12'd340, 12'd70);
    step("over.frozen2", 1'b1, 1'b0, S_OVER, 4'd0, 8'd1, 3'b001, 1'b0);
    set_frog(12'd300, 12'd400, 12'd340, 12'd440);
    step("restart", 1'b0, 1'b1, S_PLAY, 4'd3, 8'd0, 3'b000, 1'b1);
    step("restart.pulse_end", 1'b0, 1'b0, S_PLAY, 4'd3, 8'd0, 3'b000, 1'b0);
`ifdef FROG_INVULN_EN
    step("invuln.no_hit", 1'b1, 1'b0, S_PLAY, 4'd3, 8'd0, 3'b000, 1'b0);
    chk("invuln.flag", 32'(bus.o_invuln), 32'd1);
`endif
    settle("restart.settle", 4'd3, 8'd0);

    // Async reset in the middle of a hold
    bus.i_obj_en = 3'b001;
    step("hit2", 1'b1, 1'b0, S_HIT, 4'd2, 8'd0, 3'b001, 1'b0);
    for (int i = 0; i < 30; i++) step("hit2.hold", 1'b1, 1'b0, S_HIT, 4'd2, 8'd0, 3'b001, 1'b0);
    #1 rst = 1'b1;
    #1;
    push_exp("async_rst", S_PLAY, 4'd3, 8'd0, 3'b000, 1'b0);
    check_pop();
    @(negedge clk);
    rst = 1'b0;
    bus.i_obj_en = 3'b000;
    step("post_rst1", 1'b0, 1'b0, S_PLAY, 4'd3, 8'd0, 3'b000, 1'b0);
    step("post_rst2", 1'b1, 1'b0, S_PLAY, 4'd3, 8'd0, 3'b000, 1'b0);
    step("post_rst3", 1'b0, 1'b0, S_PLAY, 4'd3, 8'd0, 3'b000, 1'b0);

    // Score saturation on the narrow-score instance (hold of 2 frames)
    for (int g = 1; g <= 4; g++) begin
      @(negedge clk); bus2.i_animate = 1'b1;
      @(negedge clk); bus2.i_animate = 1'b0;
      chk("sat.state_win", 32'(bus2.o_state), 32'(S_WIN));
      chk("sat.score", 32'(bus2.o_score), (g < 3) ? 32'(g) : 32'd3);
      repeat (2) begin
        @(negedge clk); bus2.i_animate = 1'b1;
        @(negedge clk); bus2.i_animate = 1'b0;
      end
      chk("sat.state_play", 32'(bus2.o_state), 32'(S_PLAY));
    end

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frog_game_ctrl.md
Name: frog_game_ctrl

Overview:
Per-frame game supervisor for the frog/obstacle VGA game. Checks the frog bounding box against N_OBJ obstacle boxes once per frame and detects arrival at the goal row. Manages lives, score and respawn timing through a four-state FSM. Sits between the sprite movers (frog, square) and the top level; o_respawn drives the frog mover's reset in place of ad-hoc collision logic.

Parameters:
N_OBJ, 3, number of obstacle channels
COORD_W, 12, coordinate width of all box edges
LIVES, 3, lives at reset/restart (1..15)
SCORE_W, 8, score counter width
GOAL_Y, 40, frog reaches goal when frog_y1 < GOAL_Y
HOLD_FRAMES, 60, frames spent in HIT or WIN before respawn (>=1)

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous active-high reset
i_animate  in  1  one-cycle end-of-frame strobe
i_start  in  1  restart request, honoured only in OVER
i_frog_x1, i_frog_x2, i_frog_y1, i_frog_y2  in  COORD_W each  frog box edges
i_obj_x1, i_obj_x2, i_obj_y1, i_obj_y2  in  N_OBJ*COORD_W each  packed obstacle edges, channel k at [k*COORD_W +: COORD_W]
i_obj_en  in  N_OBJ  per-channel enable; a disabled channel never hits
o_state  out  2  PLAY=0, HIT=1, WIN=2, OVER=3
o_lives  out  4  remaining lives
o_score  out  SCORE_W  goals reached, saturating
o_hit_mask  out  N_OBJ  channels that caused the last hit, held until next respawn
o_respawn  out  1  one-cycle pulse: frog returns to start position

Behaviour:
- Reset (async, i_rst=1): state PLAY, lives=LIVES, score=0, hit_mask=0, respawn=0, frame timer=0. All outputs are registered.
- Overlap for channel k (combinational): i_obj_en[k] && frog_x1 < obj_x2 && frog_x2 > obj_x1 && frog_y1 < obj_y2 && frog_y2 > obj_y1. Comparisons are unsigned and strict, so edge-touching boxes do not overlap. hit = OR over channels.
- Goal = frog_y1 < GOAL_Y.
- Inputs are sampled only on cycles where i_animate=1. All state changes occur on those cycles, except the o_respawn pulse.
- PLAY, on strobe:
  - hit: hit_mask <= per-channel overlap vector; timer <= 0.
    - lives > 1: lives-1, go to HIT.
    - lives == 1: lives <= 0, go to OVER.
  - else goal: score+1, saturating at 2^SCORE_W-1; go to WIN; timer <= 0.
  - hit and goal in the same frame: hit takes priority and score is unchanged.
- HIT or WIN, on strobe: timer+1. When timer reaches HOLD_FRAMES-1, go to PLAY, clear hit_mask, and assert o_respawn on the next cycle for exactly one cycle.
- OVER: frozen; strobes are ignored. On i_start=1 (any cycle): lives=LIVES, score=0, hit_mask=0, go to PLAY, o_respawn pulses one cycle.
- i_start outside OVER is ignored.
- Mid-operation reset: the async assertion clears everything immediately, and any pending o_respawn is dropped.
- Latency: strobe to o_state/o_lives/o_score update is 1 cycle.

Optional Feature:
FROG_INVULN_EN
- Defined: after every respawn, an invulnerability counter loads HOLD_FRAMES. While it is nonzero, the hit check is suppressed in PLAY (goal detection remains active). The counter decrements on each strobe. A 1-bit output o_invuln is added, high while the counter is nonzero.
- Undefined: the counter and port are absent, and hits are checked on the first frame after respawn.

Decomposition:
- Package frog_game_pkg holds:
  - state encoding constants (PLAY, HIT, WIN, OVER)
  - default COORD_W
  - a function that unpacks channel k from a packed coordinate vector
- One natural sub-module, box_overlap: combinational strict AABB test with parameter COORD_W. It is instantiated N_OBJ times in a generate loop; the FSM stays in frog_game_ctrl.

Test Plan:
1. Overlap: frog (300,400)-(340,440), obj0 (320,410)-(400,430), enabled, strobe → state HIT, lives 3→2, hit_mask=3'b001. After 60 strobes, o_respawn pulses once and hit_mask=0.
2. Edge touch and enable: frog x2=320, obj0 x1=320 → no hit. Fully overlapping obj1 with i_obj_en[1]=0 → no hit, state stays PLAY.
3. Goal: frog_y1=30 with no overlap → score 0→1, state WIN, respawn after 60 frames. Drive SCORE_W=2 to four goals → score stays 3.
4. Priority: frog_y1=30 overlapping obj2 in the same frame → HIT, score unchanged, hit_mask=3'b100.
5. Game over and restart: three separate hits → lives 0, state OVER, further strobes ignored. i_start → lives 3, score 0, state PLAY, single-cycle o_respawn.
6. Async reset asserted while in HIT with timer=30 → state PLAY and lives 3 immediately, before the next clock edge, with no respawn pulse. With FROG_INVULN_EN defined, an overlap within 60 frames of respawn → no hit.
